// File: rtl/multi_gate_seq.sv
// multi_gate_seq: registered WIDTH-input reduction gate on a valid/ready stream.
// Truth-table sweep engine is built only with MULTI_GATE_SEQ_SWEEP_EN defined.
module multi_gate_seq #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_data,
    output logic             op_err,
    input  logic             sweep_start,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic [WIDTH:0]   sweep_ones
);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    // Reserved ops (6/7) reduce to 0.
    function automatic logic gate_fn(
        input logic [2:0]       f,
        input logic [WIDTH-1:0] v
    );
        logic r;
        r = 1'b0;
        case (f)
            OP_AND:  r = &v;
            OP_OR:   r = |v;
            OP_XOR:  r = ^v;
            OP_NAND: r = ~&v;
            OP_NOR:  r = ~|v;
            OP_XNOR: r = ~^v;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_rsvd(input logic [2:0] f);
        return f[2] & f[1];
    endfunction

    logic stream_idle;
    logic accept;
    logic out_valid_nx;

    assign in_ready     = stream_idle & (~out_valid | out_ready);
    assign accept       = in_valid & in_ready;
    assign out_valid_nx = accept | (out_valid & ~out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 1'b0;
            op_err    <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= gate_fn(op, in_data);
            op_err    <= is_rsvd(op);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MULTI_GATE_SEQ_SWEEP_EN

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        SWEEP,
        DONE
    } state_t;

    localparam logic [WIDTH:0] LAST =
        (WIDTH+1)'((1 << WIDTH) - 1);

    state_t         state;
    state_t         state_nx;
    logic           sweep_go;
    logic [2:0]     sop;
    logic [WIDTH:0] cnt;
    logic [WIDTH:0] ones;

    assign stream_idle = (state == IDLE);
    assign sweep_busy  = (state == DRAIN) |
                         (state == SWEEP);
    assign sweep_done  = (state == DONE);
    assign sweep_ones  = ones;

    always_comb begin
        state_nx = state;
        sweep_go = 1'b0;
        unique case (state)
            IDLE: begin
                if (sweep_start) begin
                    sweep_go = 1'b1;
                    // A result still held after this edge must drain first.
                    state_nx = out_valid_nx ? DRAIN : SWEEP;
                end
            end
            DRAIN: begin
                if (!out_valid || out_ready)
                    state_nx = SWEEP;
            end
            SWEEP: begin
                if (cnt == LAST)
                    state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sop   <= 3'd0;
            cnt   <= '0;
            ones  <= '0;
        end else begin
            state <= state_nx;
            if (sweep_go) begin
                sop  <= op;
                cnt  <= '0;
                ones <= '0;
            end else if (state == SWEEP) begin
                cnt  <= cnt + 1'b1;
                ones <= ones + {{WIDTH{1'b0}},
                    gate_fn(sop, cnt[WIDTH-1:0])};
            end
        end
    end

`else

    logic unused_sweep_start;

    assign unused_sweep_start = sweep_start;
    assign stream_idle        = 1'b1;
    assign sweep_busy         = 1'b0;
    assign sweep_done         = 1'b0;
    assign sweep_ones         = '0;

`endif

endmodule
